// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: binary32 layout, divider state and special-case class.
package fpu_pkg;

  localparam int unsigned FP_EXP_BIAS = 127;
  localparam int unsigned FP_EXP_MAX  = 255;
  localparam int unsigned FDIV_QBITS  = 26;
  localparam int unsigned FDIV_CNT_W  = 5;
  localparam int unsigned FP_MANT_W   = 24;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32_t;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_e;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} fdiv_spec_e;

  // Denormal operands (exp == 0) count as zero.
  function automatic fdiv_spec_e fdiv_classify(input float32_t a, input float32_t b);
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    nan_a  = (a.exp == 8'hFF) && (a.frac != 23'd0);
    nan_b  = (b.exp == 8'hFF) && (b.frac != 23'd0);
    inf_a  = (a.exp == 8'hFF) && (a.frac == 23'd0);
    inf_b  = (b.exp == 8'hFF) && (b.frac == 23'd0);
    zero_a = (a.exp == 8'h00);
    zero_b = (b.exp == 8'h00);
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) return SP_NAN;
    else if (inf_a || zero_b)                                     return SP_INF;
    else if (zero_a || inf_b)                                     return SP_ZERO;
    else                                                          return SP_NONE;
  endfunction

endpackage

// File: rtl/fdiv_iter_round.sv
// Combinational normalise / round-to-nearest-even / pack stage for the iterative divider.
module fdiv_iter_round
  import fpu_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic [FDIV_QBITS-1:0] q_i,
  input  logic                  rem_nz_i,
  input  logic                  sign_i,
  input  logic signed [9:0]     exp_i,
  input  fdiv_spec_e            spec_i,
  output logic [31:0]           y_c,
  output logic                  ovf_c,
  output logic                  udf_c
);

  logic [22:0]       frac;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic              carry;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;

  // Hidden bit is q[25] or q[24]; only the fraction below it is kept.
  always_comb begin
    frac   = q_i[25] ? q_i[24:2] : q_i[23:1];
    guard  = q_i[25] ? q_i[1]    : q_i[0];
    sticky = rem_nz_i | (q_i[25] & q_i[0]);
    exp_n  = exp_i + $signed({9'd0, q_i[25]});
    inc    = ROUND_EN && guard && (sticky || frac[0]);
    carry  = inc && (&frac);
    frac_r = frac + 23'(inc);
    exp_r  = exp_n + $signed({9'd0, carry});
  end

  always_comb begin
    y_c   = 32'd0;
    ovf_c = 1'b0;
    udf_c = 1'b0;
    case (spec_i)
      SP_NAN:  y_c = FP_QNAN;
      SP_INF:  y_c = {sign_i, 8'hFF, 23'd0};
      SP_ZERO: y_c = {sign_i, 31'd0};
      default: begin
        if (exp_r >= 10'sd255) begin
          y_c   = {sign_i, 8'hFF, 23'd0};
          ovf_c = 1'b1;
        end else if (exp_r <= 10'sd0) begin
          y_c   = {sign_i, 31'd0};
          udf_c = 1'b1;
        end else begin
          y_c = {sign_i, exp_r[7:0], frac_r};
        end
      end
    endcase
  end

endmodule

// File: rtl/fdiv_iter.sv
// Multicycle binary32 divider: restoring radix-2, one quotient bit per cycle, valid/ready handshake.
module fdiv_iter
  import fpu_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

  fdiv_state_e               state_q, state_d;
  logic [FDIV_CNT_W-1:0]     cnt_q, cnt_d;
  logic [FDIV_QBITS-1:0]     rem_q, rem_d;
  logic [FDIV_QBITS-1:0]     q_q, q_d;
  logic [FP_MANT_W-1:0]      div_q, div_d;
  logic                      sign_q, sign_d;
  logic signed [9:0]         exp_q, exp_d;
  fdiv_spec_e                spec_q, spec_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [31:0]               y_q, y_d;
  logic                      ovf_q, ovf_d;
  logic                      udf_q, udf_d;

  float32_t                  a, b;
  logic                      ge_c;
  logic [FDIV_QBITS-1:0]     rem_sub_c;
  logic [31:0]               rnd_y_c;
  logic                      rnd_ovf_c, rnd_udf_c;

  assign a = x1;
  assign b = x2;

  // Restoring step: subtract when the partial remainder covers the divisor, then shift.
  assign ge_c      = rem_q >= {2'b00, div_q};
  assign rem_sub_c = ge_c ? (rem_q - {2'b00, div_q}) : rem_q;

  fdiv_iter_round #(.ROUND_EN(ROUND_EN)) u_round (
    .q_i      (q_q),
    .rem_nz_i (rem_q != '0),
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .spec_i   (spec_q),
    .y_c      (rnd_y_c),
    .ovf_c    (rnd_ovf_c),
    .udf_c    (rnd_udf_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      div_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      spec_q      <= SP_NONE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      div_q       <= div_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      spec_q      <= spec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    q_d         = q_q;
    div_d       = div_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    spec_d      = spec_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = DIV;
          cnt_d      = '0;
          rem_d      = {2'b00, 1'b1, a.frac};
          div_d      = {1'b1, b.frac};
          q_d        = '0;
          sign_d     = a.sign ^ b.sign;
          exp_d      = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp})
                       + $signed(10'(FP_EXP_BIAS - 1));
          spec_d     = fdiv_classify(a, b);
          in_ready_d = 1'b0;
        end
      end
      DIV: begin
        rem_d = rem_sub_c << 1;
        q_d   = {q_q[FDIV_QBITS-2:0], ge_c};
        if (cnt_q == FDIV_CNT_W'(FDIV_QBITS - 1)) state_d = ROUND;
        else                                      cnt_d   = cnt_q + 1'b1;
      end
      ROUND: begin
        y_d         = rnd_y_c;
        ovf_d       = rnd_ovf_c;
        udf_d       = rnd_udf_c;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: rounding and truncating instances side by side.
module tb_fdiv_iter;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x1, x2;
  logic        out_ready;
  logic        in_ready, in_ready_t;
  logic        out_valid, out_valid_t;
  logic [31:0] y, y_t;
  logic        ovf, ovf_t, udf, udf_t;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  fdiv_iter #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .udf(udf)
  );

  fdiv_iter #(.ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
    .x1(x1), .x2(x2), .out_valid(out_valid_t), .out_ready(out_ready),
    .y(y_t), .ovf(ovf_t), .udf(udf_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns edges elapsed since the accept edge when out_valid is seen.
  task automatic wait_valid(input string tag, output int k);
    k = 0;
    while (!out_valid) begin
      if (k >= 100) begin
        check({tag, "_timeout"}, 32'(out_valid), 32'd1);
        break;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic [31:0] ey_t,
                        input logic eovf, input logic eudf, input bit chk_lat);
    int k;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x1 = 32'hDEAD_BEEF;
    x2 = 32'h1234_5678;
    @(negedge clk);
    wait_valid(tag, k);
    // k+1 is the first rising edge at which out_valid is sampled high
    if (chk_lat) check({tag, "_latency"}, 32'(k + 1), 32'd28);
    check({tag, "_y"},    y,          ey);
    check({tag, "_ovf"},  32'(ovf),   32'(eovf));
    check({tag, "_udf"},  32'(udf),   32'(eudf));
    check({tag, "_y_tr"}, y_t,        ey_t);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int k;
    int rises;
    logic [31:0] y_hold;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    x1        = '0;
    x2        = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y",         y,              32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_udf",       32'(udf),       32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op("6div2",    32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b1);
    run_op("1div3",    32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 32'h3EAA_AAAA, 1'b0, 1'b0, 1'b1);
    run_op("1div0",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1'b1);
    run_op("0div0",    32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0);
    run_op("m1divinf", 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("ovf",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    run_op("udf",      32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Backpressure: result held for 10 cycles while a second request waits.
    @(negedge clk);
    in_valid = 1'b1;
    x1 = 32'h40C0_0000;
    x2 = 32'h4000_0000;
    @(posedge clk);
    #1;
    x1 = 32'h4000_0000;
    x2 = 32'h3F80_0000;
    @(negedge clk);
    wait_valid("bp", k);
    check("bp_latency", 32'(k + 1), 32'd28);
    check("bp_y", y, 32'h4040_0000);
    y_hold = y;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y_stable", y,               y_hold);
      check("bp_in_ready", 32'(in_ready),   32'd0);
      check("bp_valid",    32'(out_valid),  32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_not_taken_in_done", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x1 = '0;
    x2 = '0;
    @(negedge clk);
    check("bp_second_taken", 32'(in_ready), 32'd0);
    wait_valid("bp2", k);
    check("bp2_latency", 32'(k + 1), 32'd28);
    check("bp2_y", y, 32'h4000_0000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during DIV cycle 10 aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    x1 = 32'h3F80_0000;
    x2 = 32'h4040_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_y",         y,              32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("arst_no_stale_valid", 32'(rises), 32'd0);
    run_op("post_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
